alu_multicycle: RTL

//  Parametrised execute-stage ALU, successor to the single-cycle 64-bit ALU.
//  - Keeps the existing 4-bit control encodings and adds iterative MUL/DIVU/REMU.
//  - Registered result with a start/ready/valid handshake so the pipeline can stall on long ops.
//  - Sits in EX; the hazard unit holds ID/EX while ready_o=0.

---
 rtl/alu_multicycle.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle logic ops and iterative MUL/DIVU/REMU
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_MUL = 4'b1000, OP_DIVU = 4'b1010, OP_REMU = 4'b1011;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic rem_sel;
  logic [WIDTH-1:0] result;
  logic valid, zero, illegal;
  logic [WIDTH-1:0] alu_res;
  logic alu_ill;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0] div_r, div_d;
  logic div_ge;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic last;
  assign ready_o   = (state == IDLE);
  assign valid_o   = valid;
  assign result_o  = result;
  assign zero_o    = zero;
  assign illegal_o = illegal;
  // single-cycle ALU result for codes handled directly in IDLE
  always_comb begin
    alu_res = '0;
    alu_ill = !(ctrl_i inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR});
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      default: alu_res = '0;
    endcase
  end
  // one iteration step: shift-add multiply and restoring division (opa=quotient, acc=remainder)
  always_comb begin
    mul_acc = acc + (opb[0] ? opa : '0);
    div_r   = {acc, opa[WIDTH-1]};
    div_d   = div_r - {1'b0, opb};
    div_ge  = div_r >= {1'b0, opb};
    div_rem = div_ge ? div_d[WIDTH-1:0] : div_r[WIDTH-1:0];
    div_quo = {opa[WIDTH-2:0], div_ge};
    last    = (cnt == CNT_W'(1));
  end
  // control FSM with registered result and status
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      rem_sel <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      valid   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          if (ctrl_i inside {OP_MUL, OP_DIVU, OP_REMU}) begin
            opa     <= src1_i;
            opb     <= src2_i;
            acc     <= '0;
            cnt     <= CNT_INIT;
            rem_sel <= ctrl_i[0];
            state   <= (ctrl_i == OP_MUL) ? MUL : DIV;
          end else begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= alu_ill;
            valid   <= 1'b1;
          end
        end
        MUL: if (flush_i) state <= IDLE;
        else begin
          acc <= mul_acc;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            result  <= mul_acc;
            zero    <= (mul_acc == '0);
            illegal <= 1'b0;
            valid   <= 1'b1;
            state   <= IDLE;
          end
        end
        DIV: if (flush_i) state <= IDLE;
        else begin
          acc <= div_rem;
          opa <= div_quo;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            result  <= rem_sel ? div_rem : div_quo;
            zero    <= ((rem_sel ? div_rem : div_quo) == '0);
            illegal <= 1'b0;
            valid   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
